// File: rtl/elelock_pkg.sv
// Shared types and helpers for the multi-digit electronic lock.
package elelock_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED  = 2'd0,
        ST_CHECK   = 2'd1,
        ST_OPEN    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_e;

    localparam logic [3:0] KEY_NONE = 4'hF;

    // One-hot keypad to digit; anything not exactly one-hot maps to KEY_NONE.
    function automatic logic [3:0] keyenc(input logic [9:0] k);
        logic [3:0] r;
        logic [3:0] n;
        r = KEY_NONE;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (k[i]) begin
                r = 4'(i);
                n = n + 4'd1;
            end
        end
        if (n != 4'd1) begin
            r = KEY_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/elelock_multi_tenkey_press.sv
// Keypad edge detector: one press per release-to-one-hot transition.
import elelock_pkg::*;

module tenkey_press (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] tenkey,
    output logic       press_valid,
    output logic [3:0] press_digit
);

    logic [9:0] prev_q;
    logic       armed_q;

    // armed_q blocks a key that was already held through reset until it is released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q  <= '0;
            armed_q <= (tenkey == 10'd0);
        end else begin
            prev_q <= tenkey;
            if (tenkey == 10'd0) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign press_digit = keyenc(tenkey);
    assign press_valid = armed_q && (prev_q == 10'd0) && (press_digit != KEY_NONE);

endmodule

// File: rtl/elelock_multi.sv
// Multi-digit code lock with failed-attempt counter, timed lockout and idle discard.
import elelock_pkg::*;

module elelock_multi #(
    parameter int                DIGITS         = 4,
    parameter logic [DIGITS*4-1:0] SECRET       = 16'h1234,
    parameter int                MAX_FAIL       = 3,
    parameter logic [15:0]       LOCKOUT_CYCLES = 16'd1000,
    parameter logic [15:0]       IDLE_TIMEOUT   = 16'd5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] tenkey,
    input  logic       close,
    output logic       lock,
    output logic       alarm,
    output logic [3:0] fail_cnt,
    output logic [3:0] digit_cnt
);

    localparam int         W       = DIGITS * 4;
    localparam logic [3:0] DIGITS_C = 4'(DIGITS);
    localparam logic [3:0] MAXF_C   = 4'(MAX_FAIL);

    state_e         state_q, state_d;
    logic [W-1:0]   entry_q, entry_d, entry_shift;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     fail_q, fail_d, fail_inc;
    logic [15:0]    timer_q, timer_d;
    logic           press_valid;
    logic [3:0]     press_digit;

    tenkey_press u_press (
        .clk         (clk),
        .rst_n       (rst_n),
        .tenkey      (tenkey),
        .press_valid (press_valid),
        .press_digit (press_digit)
    );

    if (DIGITS > 1) begin : g_shift
        assign entry_shift = {entry_q[W-5:0], press_digit};
    end else begin : g_single
        assign entry_shift = press_digit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_LOCKED;
            entry_q <= '0;
            cnt_q   <= '0;
            fail_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
        end
    end

    // The single timer serves the idle timeout in LOCKED and the lockout countdown.
    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        cnt_d    = cnt_q;
        fail_d   = fail_q;
        timer_d  = timer_q;
        fail_inc = (fail_q < MAXF_C) ? fail_q + 4'd1 : fail_q;
        case (state_q)
            ST_LOCKED: begin
                if (close) begin
                    entry_d = '0;
                    cnt_d   = '0;
                    timer_d = '0;
                end else if (press_valid) begin
                    entry_d = entry_shift;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == DIGITS_C) begin
                        state_d = ST_CHECK;
                        timer_d = '0;
                    end else begin
                        timer_d = IDLE_TIMEOUT;
                    end
                end else if (cnt_q != 4'd0) begin
                    if (timer_q <= 16'd1) begin
                        entry_d = '0;
                        cnt_d   = '0;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - 16'd1;
                    end
                end
            end
            ST_CHECK: begin
                entry_d = '0;
                cnt_d   = '0;
                if (entry_q == SECRET) begin
                    state_d = ST_OPEN;
                    fail_d  = '0;
                end else begin
                    fail_d = fail_inc;
                    if (fail_inc == MAXF_C) begin
                        state_d = ST_LOCKOUT;
                        timer_d = LOCKOUT_CYCLES;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_OPEN: begin
                if (close) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKOUT: begin
                if (timer_q <= 16'd1) begin
                    state_d = ST_LOCKED;
                    fail_d  = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_LOCKED;
            end
        endcase
    end

    assign lock      = (state_q != ST_OPEN);
    assign alarm     = (state_q == ST_LOCKOUT);
    assign fail_cnt  = fail_q;
    assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_elelock_multi.sv
// Scoreboard bench: stimulus queues expected outputs per edge, a monitor checks them.
module tb_elelock_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] tenkey;
    logic       close;
    logic       lock, alarm;
    logic [3:0] fail_cnt, digit_cnt;

    int edge_n = 0;
    int chk_id = 0;
    int n_cmp  = 0;
    int n_bad  = 0;

    typedef struct {
        int         edge_no;
        int         id;
        logic       lock;
        logic       alarm;
        logic [3:0] fail;
        logic [3:0] dcnt;
    } exp_t;

    exp_t sb[$];

    elelock_multi #(
        .DIGITS         (4),
        .SECRET         (16'h1234),
        .MAX_FAIL       (3),
        .LOCKOUT_CYCLES (16'd8),
        .IDLE_TIMEOUT   (16'd16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tenkey    (tenkey),
        .close     (close),
        .lock      (lock),
        .alarm     (alarm),
        .fail_cnt  (fail_cnt),
        .digit_cnt (digit_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].edge_no <= edge_n) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.edge_no != edge_n || lock !== e.lock || alarm !== e.alarm ||
                fail_cnt !== e.fail || digit_cnt !== e.dcnt) begin
                n_bad++;
                $display("FAIL chk%0d edge %0d: got lock=%b alarm=%b fail_cnt=%0d digit_cnt=%0d, want lock=%b alarm=%b fail_cnt=%0d digit_cnt=%0d at edge %0d",
                         e.id, edge_n, lock, alarm, fail_cnt, digit_cnt,
                         e.lock, e.alarm, e.fail, e.dcnt, e.edge_no);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic want(input logic l, input logic a, input logic [3:0] f, input logic [3:0] d);
        exp_t e;
        e.edge_no = edge_n;
        e.id      = chk_id;
        e.lock    = l;
        e.alarm   = a;
        e.fail    = f;
        e.dcnt    = d;
        sb.push_back(e);
        chk_id++;
    endtask

    task automatic press_key(input int d, input int hold, input int gap);
        tenkey = 10'd1 << d;
        tick(hold);
        tenkey = '0;
        tick(gap);
    endtask

    // Enters three digits normally, then samples the last one and stops one edge after it
    // (state CHECK). The key is left held; the caller checks the outcome edge.
    task automatic enter_code(input logic [15:0] code, input logic [3:0] f);
        for (int i = 0; i < 3; i++) begin
            press_key(int'(code[4*(3-i) +: 4]), 3, 2);
            want(1'b1, 1'b0, f, 4'(i + 1));
        end
        tenkey = 10'd1 << code[3:0];
        tick(1);
        want(1'b1, 1'b0, f, 4'd4);
        tick(1);
    endtask

    task automatic release_key();
        tenkey = '0;
        tick(2);
    endtask

    initial begin
        rst_n  = 1'b0;
        tenkey = '0;
        close  = 1'b0;
        tick(2);
        want(1'b1, 1'b0, 4'd0, 4'd0);
        rst_n = 1'b1;
        tick(1);

        // correct code unlocks one edge after the last digit
        enter_code(16'h1234, 4'd0);
        want(1'b0, 1'b0, 4'd0, 4'd0);
        release_key();
        want(1'b0, 1'b0, 4'd0, 4'd0);

        close = 1'b1;
        tick(1);
        want(1'b1, 1'b0, 4'd0, 4'd0);
        close = 1'b0;
        tick(1);

        enter_code(16'h1235, 4'd0);
        want(1'b1, 1'b0, 4'd1, 4'd0);
        release_key();

        enter_code(16'h1111, 4'd1);
        want(1'b1, 1'b0, 4'd2, 4'd0);
        release_key();

        // third failure: lockout of exactly 8 cycles, keys ignored throughout
        enter_code(16'h9999, 4'd2);
        want(1'b1, 1'b1, 4'd3, 4'd0);
        tenkey = '0;
        tick(1);
        want(1'b1, 1'b1, 4'd3, 4'd0);
        for (int i = 1; i <= 3; i++) begin
            tenkey = 10'd1 << i;
            tick(1);
            want(1'b1, 1'b1, 4'd3, 4'd0);
            tenkey = '0;
            tick(1);
            want(1'b1, 1'b1, 4'd3, 4'd0);
        end
        tenkey = 10'd1 << 4;
        tick(1);
        want(1'b1, 1'b0, 4'd0, 4'd0);
        tenkey = '0;
        tick(1);
        want(1'b1, 1'b0, 4'd0, 4'd0);

        // idle timeout: last press at p, entry discarded exactly at p+16
        press_key(1, 3, 2);
        want(1'b1, 1'b0, 4'd0, 4'd1);
        press_key(2, 3, 2);
        want(1'b1, 1'b0, 4'd0, 4'd2);
        tick(11);
        want(1'b1, 1'b0, 4'd0, 4'd2);
        tick(1);
        want(1'b1, 1'b0, 4'd0, 4'd0);
        enter_code(16'h1234, 4'd0);
        want(1'b0, 1'b0, 4'd0, 4'd0);
        release_key();
        close = 1'b1;
        tick(1);
        close = 1'b0;
        want(1'b1, 1'b0, 4'd0, 4'd0);

        // long hold, key-to-multi-hot without release, close beats a press
        tenkey = 10'd1 << 1;
        tick(10);
        want(1'b1, 1'b0, 4'd0, 4'd1);
        tenkey = 10'b00_0000_0011;
        tick(2);
        tenkey = '0;
        tick(1);
        want(1'b1, 1'b0, 4'd0, 4'd1);
        tenkey = 10'd1 << 2;
        close  = 1'b1;
        tick(1);
        want(1'b1, 1'b0, 4'd0, 4'd0);
        close = 1'b0;
        tick(2);
        want(1'b1, 1'b0, 4'd0, 4'd0);
        release_key();
        tenkey = 10'b00_0000_0011;
        tick(2);
        want(1'b1, 1'b0, 4'd0, 4'd0);
        release_key();

        // key held through reset must be released before it counts
        tenkey = 10'd1 << 4;
        rst_n  = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        want(1'b1, 1'b0, 4'd0, 4'd0);
        release_key();
        press_key(4, 2, 2);
        want(1'b1, 1'b0, 4'd0, 4'd1);
        close = 1'b1;
        tick(1);
        close = 1'b0;

        // reset during lockout and during a partial entry
        enter_code(16'h5678, 4'd0);
        release_key();
        enter_code(16'h5678, 4'd1);
        release_key();
        enter_code(16'h5678, 4'd2);
        want(1'b1, 1'b1, 4'd3, 4'd0);
        release_key();
        want(1'b1, 1'b1, 4'd3, 4'd0);
        rst_n = 1'b0;
        tick(1);
        want(1'b1, 1'b0, 4'd0, 4'd0);
        rst_n = 1'b1;
        tick(1);
        press_key(1, 3, 2);
        press_key(2, 3, 2);
        want(1'b1, 1'b0, 4'd0, 4'd2);
        rst_n = 1'b0;
        tick(1);
        want(1'b1, 1'b0, 4'd0, 4'd0);
        rst_n = 1'b1;
        tick(1);
        enter_code(16'h1234, 4'd0);
        want(1'b0, 1'b0, 4'd0, 4'd0);
        release_key();

        // reset while open
        rst_n = 1'b0;
        tick(1);
        want(1'b1, 1'b0, 4'd0, 4'd0);
        rst_n = 1'b1;
        tick(2);

        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
